// File: rtl/qbit_ctrl_pkg.sv
// rtl/qbit_ctrl_pkg.sv - shared FSM/operation types for the differential qbit access controller
package qbit_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_ACTIVATE,
    ST_SENSE,
    ST_WRITEBACK,
    ST_RESPOND
  } state_e;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_REFRESH
  } op_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/qbit_refresh_timer.sv
// rtl/qbit_refresh_timer.sv - refresh interval counter, pending flag and wrapping cell pointer
module qbit_refresh_timer #(
  parameter int NUM_CELLS        = 16,
  parameter int ADDR_W           = $clog2(NUM_CELLS),
  parameter int REFRESH_INTERVAL = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  output logic              pending_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int CNT_W = ($clog2(REFRESH_INTERVAL) > 0) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NUM_CELLS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              expire;

  assign expire = (cnt_q == CNT_LAST);

  // An expiry while already pending simply re-asserts the flag; a new expiry outranks a clear.
  always_comb begin
    cnt_d     = expire ? '0 : cnt_q + 1'b1;
    pending_d = pending_q;
    ptr_d     = ptr_q;
    if (clear_i) begin
      pending_d = 1'b0;
      ptr_d     = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
    if (expire) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
    end
  end

  assign pending_o = pending_q;
  assign addr_o    = ptr_q;

endmodule

// File: rtl/qbit_access_ctrl.sv
// rtl/qbit_access_ctrl.sv - precharge/activate/sense/write-back sequencer for a shared differential bitline pair
// Optional periodic refresh is built when QBIT_REFRESH_EN is defined.
module qbit_access_ctrl
  import qbit_ctrl_pkg::*;
#(
  parameter int NUM_CELLS        = 16,
  parameter int ADDR_W           = $clog2(NUM_CELLS),
  parameter int PRECHARGE_CYCLES = 2,
  parameter int SENSE_CYCLES     = 3,
  parameter int REFRESH_INTERVAL = 1024
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [ADDR_W-1:0]    ReqAddr,
  input  logic                 ReqData,
  output logic                 RspValid,
  output logic                 RspData,
  output logic                 RspFault,
  output logic                 PrechargeEn,
  output logic [NUM_CELLS-1:0] WordLine,
  output logic                 SenseEn,
  output logic                 WriteEn,
  output logic                 WriteN,
  output logic                 WriteS,
  input  logic                 SenseN,
  input  logic                 SenseS,
  output logic                 Busy
);

  localparam int CNT_W = $clog2(max_int(PRECHARGE_CYCLES, SENSE_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRECHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SENSE_LAST = CNT_W'(SENSE_CYCLES - 1);

  if (NUM_CELLS < 2 || PRECHARGE_CYCLES < 1 || SENSE_CYCLES < 1 || REFRESH_INTERVAL < 1) begin : g_param_check
    $error("qbit_access_ctrl: illegal parameter value");
  end

  state_e                state_q;
  op_e                   op_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  data_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  sense_s_q, fault_q;
  logic                  alive_q, busy_q;
  logic                  precharge_q, sense_en_q, write_en_q, write_n_q, write_s_q;
  logic [NUM_CELLS-1:0]  word_line_q;
  logic                  rsp_valid_q, rsp_data_q, rsp_fault_q;

  logic                  refresh_pending;
  logic [ADDR_W-1:0]     refresh_addr;
  logic [NUM_CELLS-1:0]  wl_sel;
  logic                  addr_ok, samp_s, samp_fault, wb_val, req_ready;

`ifdef QBIT_REFRESH_EN
  logic refresh_clear;
  assign refresh_clear = (state_q == ST_WRITEBACK) && (op_q == OP_REFRESH);

  qbit_refresh_timer #(
    .NUM_CELLS       (NUM_CELLS),
    .ADDR_W          (ADDR_W),
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh (
    .clk_i    (Clk),
    .rst_ni   (ResetN),
    .clear_i  (refresh_clear),
    .pending_o(refresh_pending),
    .addr_o   (refresh_addr)
  );
`else
  assign refresh_pending = 1'b0;
  assign refresh_addr    = '0;
`endif

  // An out-of-range address decodes to an all-zero wordline, which also marks the access invalid.
  always_comb begin
    wl_sel = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      wl_sel[i] = (addr_q == ADDR_W'(i));
    end
  end

  assign addr_ok    = |wl_sel;
  assign samp_s     = addr_ok & SenseS;
  assign samp_fault = ~addr_ok | (SenseN == SenseS);
  assign wb_val     = (op_q == OP_WRITE) ? data_q : samp_s;
  assign req_ready  = alive_q && (state_q == ST_IDLE) && !refresh_pending;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      data_q      <= 1'b0;
      cnt_q       <= '0;
      sense_s_q   <= 1'b0;
      fault_q     <= 1'b0;
      alive_q     <= 1'b0;
      busy_q      <= 1'b0;
      precharge_q <= 1'b0;
      word_line_q <= '0;
      sense_en_q  <= 1'b0;
      write_en_q  <= 1'b0;
      write_n_q   <= 1'b0;
      write_s_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
      rsp_fault_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (refresh_pending || (ReqValid && req_ready)) begin
            state_q     <= ST_PRECHARGE;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            precharge_q <= 1'b1;
            if (refresh_pending) begin
              op_q   <= OP_REFRESH;
              addr_q <= refresh_addr;
            end else begin
              op_q   <= ReqWrite ? OP_WRITE : OP_READ;
              addr_q <= ReqAddr;
              data_q <= ReqData;
            end
          end
        end
        ST_PRECHARGE: begin
          if (cnt_q == PRE_LAST) begin
            state_q     <= ST_ACTIVATE;
            precharge_q <= 1'b0;
            word_line_q <= wl_sel;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ACTIVATE: begin
          state_q    <= ST_SENSE;
          cnt_q      <= '0;
          sense_en_q <= 1'b1;
        end
        ST_SENSE: begin
          if (cnt_q == SENSE_LAST) begin
            state_q    <= ST_WRITEBACK;
            sense_en_q <= 1'b0;
            sense_s_q  <= samp_s;
            fault_q    <= samp_fault;
            write_en_q <= 1'b1;
            write_s_q  <= wb_val;
            write_n_q  <= ~wb_val;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WRITEBACK: begin
          write_en_q  <= 1'b0;
          write_s_q   <= 1'b0;
          write_n_q   <= 1'b0;
          word_line_q <= '0;
          if (op_q == OP_READ) begin
            state_q     <= ST_RESPOND;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= sense_s_q;
            rsp_fault_q <= fault_q;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_RESPOND: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_data_q  <= 1'b0;
          rsp_fault_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ReqReady    = req_ready;
  assign RspValid    = rsp_valid_q;
  assign RspData     = rsp_data_q;
  assign RspFault    = rsp_fault_q;
  assign PrechargeEn = precharge_q;
  assign WordLine    = word_line_q;
  assign SenseEn     = sense_en_q;
  assign WriteEn     = write_en_q;
  assign WriteN      = write_n_q;
  assign WriteS      = write_s_q;
  assign Busy        = busy_q;

endmodule
